// File: rtl/ssd_pkg.sv
// Shared types and segment encoding for the multiplexed seven-segment display driver.
package ssd_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StScan = 1'b1
  } ssd_state_e;

  localparam logic [6:0] SegBlank = 7'h00;

  // Active-high segments, bit0 = a .. bit6 = g; element [n] encodes hex digit n.
  localparam logic [15:0][6:0] SegHexTable = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SegHexTable[nib];
  endfunction

endpackage

// File: rtl/multi_digit_ssd_mux_if.sv
// Bundle of the display driver's data/control inputs and multiplexed outputs.
interface multi_digit_ssd_mux_if #(
  parameter int unsigned Digits = 2
) ();

  logic                  enable;
  logic [4*Digits-1:0]   value;
  logic [Digits-1:0]     dp;
  logic                  load;
  logic                  lz_blank;
  logic [3:0]            brightness;
  logic [6:0]            segments;
  logic                  dp_out;
  logic [Digits-1:0]     digit_sel;
  logic                  frame_done;

  modport master (
    output enable, value, dp, load, lz_blank, brightness,
    input  segments, dp_out, digit_sel, frame_done
  );

  modport slave (
    input  enable, value, dp, load, lz_blank, brightness,
    output segments, dp_out, digit_sel, frame_done
  );

endinterface

// File: rtl/ssd_scan_timer.sv
// Scan sequencer: idle/scan FSM with sub-slot counter, 16-phase PWM counter and digit index.
// Outputs are next-state values so the parent can register outputs on the same edge.
module ssd_scan_timer
  import ssd_pkg::*;
#(
  parameter int unsigned Digits = 2,
  parameter int unsigned SubDiv = 12500,
  localparam int unsigned DigW  = $clog2(Digits),
  localparam int unsigned SubW  = $clog2(SubDiv)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  output logic            scan_o,
  output logic            start_o,
  output logic            frame_o,
  output logic [DigW-1:0] digit_o,
  output logic [3:0]      phase_o
);

  ssd_state_e      state_q, state_d;
  logic [SubW-1:0] sub_q, sub_d;
  logic [3:0]      phase_q, phase_d;
  logic [DigW-1:0] digit_q, digit_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sub_q   <= '0;
      phase_q <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      phase_q <= phase_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    phase_d = phase_q;
    digit_d = digit_q;
    start_o = 1'b0;
    frame_o = 1'b0;
    case (state_q)
      StIdle: begin
        // Counters are already zero while idle, so entry starts at digit 0, phase 0.
        if (enable_i) begin
          state_d = StScan;
          start_o = 1'b1;
        end
      end
      StScan: begin
        if (!enable_i) begin
          state_d = StIdle;
          sub_d   = '0;
          phase_d = '0;
          digit_d = '0;
        end else if (sub_q == SubW'(SubDiv - 1)) begin
          sub_d   = '0;
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'hF) begin
            if (digit_q == DigW'(Digits - 1)) begin
              digit_d = '0;
              frame_o = 1'b1;
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign scan_o  = (state_d == StScan);
  assign digit_o = digit_d;
  assign phase_o = phase_d;

endmodule

// File: rtl/multi_digit_ssd_mux.sv
// Multiplexed hex seven-segment driver with PWM brightness, leading-zero blanking and
// frame-synchronous double-buffered display value.
module multi_digit_ssd_mux
  import ssd_pkg::*;
#(
  parameter int unsigned PAR_DIGITS  = 2,
  parameter int unsigned PAR_SUB_DIV = 12500
) (
  input  logic                    i_clk_20mhz,
  input  logic                    i_rst_20mhz,
  input  logic                    i_enable,
  input  logic [4*PAR_DIGITS-1:0] i_value,
  input  logic [PAR_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic                    i_lz_blank,
  input  logic [3:0]              i_brightness,
  output logic [6:0]              o_segments,
  output logic                    o_dp,
  output logic [PAR_DIGITS-1:0]   o_digit_sel,
  output logic                    o_frame_done
);

  localparam int unsigned DigW = $clog2(PAR_DIGITS);

  logic            scan, start, frame;
  logic [DigW-1:0] digit;
  logic [3:0]      phase;

  ssd_scan_timer #(
    .Digits (PAR_DIGITS),
    .SubDiv (PAR_SUB_DIV)
  ) u_scan_timer (
    .clk_i    (i_clk_20mhz),
    .rst_ni   (i_rst_20mhz),
    .enable_i (i_enable),
    .scan_o   (scan),
    .start_o  (start),
    .frame_o  (frame),
    .digit_o  (digit),
    .phase_o  (phase)
  );

  logic [4*PAR_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [PAR_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [PAR_DIGITS-1:0]   sel_q, sel_d;
  logic                    fd_q, fd_d;

  logic [PAR_DIGITS-1:0]   blank;
  logic                    zeros_above;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, lit;

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
    if (!i_rst_20mhz) begin
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      sel_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
      fd_q       <= fd_d;
    end
  end

  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    if (i_load) begin
      pend_val_d = i_value;
      pend_dp_d  = i_dp;
    end

    // A load on the swap edge bypasses the pending buffer.
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    if (start || frame) begin
      act_val_d = i_load ? i_value : pend_val_q;
      act_dp_d  = i_load ? i_dp    : pend_dp_q;
    end

    // Blank a digit when it and every more significant digit are zero; digit 0 is never blanked.
    blank       = '0;
    zeros_above = 1'b1;
    for (int i = int'(PAR_DIGITS) - 1; i >= 1; i--) begin
      zeros_above = zeros_above & (act_val_d[4*i +: 4] == 4'h0);
      blank[i]    = i_lz_blank & zeros_above;
    end

    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_d     = '0;
    for (int i = 0; i < int'(PAR_DIGITS); i++) begin
      if (DigW'(i) == digit) begin
        cur_nib   = act_val_d[4*i +: 4];
        cur_dp    = act_dp_d[i];
        cur_blank = blank[i];
        sel_d[i]  = 1'b1;
      end
    end

    // Phase 0 is always dark to hide ghosting while the digit select switches.
    lit  = (phase != 4'd0) && (phase <= i_brightness);
    seg_d = SegBlank;
    dp_d  = 1'b0;
    fd_d  = 1'b0;
    if (scan) begin
      fd_d = frame;
      if (lit) begin
        seg_d = cur_blank ? SegBlank : hex_to_seg(cur_nib);
        dp_d  = cur_dp;
      end
    end else begin
      sel_d = '0;
    end
  end

  assign o_segments   = seg_q;
  assign o_dp         = dp_q;
  assign o_digit_sel  = sel_q;
  assign o_frame_done = fd_q;

endmodule

// File: tb/tb_multi_digit_ssd_mux.sv
// Scoreboard bench for multi_digit_ssd_mux with 4 digits and 4 clocks per sub-slot.
module tb_multi_digit_ssd_mux;

  localparam int unsigned Digits = 4;
  localparam int unsigned SubDiv = 4;
  localparam int          DigPer = 64;
  localparam int          Frame  = 256;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multi_digit_ssd_mux_if #(.Digits(Digits)) bus ();

  multi_digit_ssd_mux #(
    .PAR_DIGITS  (Digits),
    .PAR_SUB_DIV (SubDiv)
  ) dut (
    .i_clk_20mhz  (clk),
    .i_rst_20mhz  (rst_n),
    .i_enable     (bus.enable),
    .i_value      (bus.value),
    .i_dp         (bus.dp),
    .i_load       (bus.load),
    .i_lz_blank   (bus.lz_blank),
    .i_brightness (bus.brightness),
    .o_segments   (bus.segments),
    .o_dp         (bus.dp_out),
    .o_digit_sel  (bus.digit_sel),
    .o_frame_done (bus.frame_done)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    logic       fd;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    frame_cnt = 0;
  int    lit_cnt = 0;
  int    sel_cnt = 0;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state, advanced once per clock by tick().
  logic        m_scan;
  int          m_k;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_adp, m_pdp;
  logic        rst_next, nx_en, nx_lz;
  logic [3:0]  nx_br;
  string       tag;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Drive one clock of stimulus and queue the outputs expected after the next rising edge.
  task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d);
    obs_t e;
    int   dg, ph;
    logic fr, lit, blank;
    @(negedge clk);
    rst_n = rst_next;
    bus.enable = nx_en;
    bus.lz_blank = nx_lz;
    bus.brightness = nx_br;
    bus.load = ld;
    bus.value = v;
    bus.dp = d;
    e = '0;
    fr = 1'b0;
    if (!rst_n) begin
      m_scan = 1'b0; m_k = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0;
    end else begin
      if (!m_scan) begin
        if (nx_en) begin
          m_scan = 1'b1; m_k = 0;
          m_act = ld ? v : m_pend;
          m_adp = ld ? d : m_pdp;
        end
      end else if (!nx_en) begin
        m_scan = 1'b0;
      end else begin
        m_k++;
        if (m_k % Frame == 0) begin
          fr = 1'b1;
          m_act = ld ? v : m_pend;
          m_adp = ld ? d : m_pdp;
        end
      end
      if (ld) begin
        m_pend = v; m_pdp = d;
      end
      if (m_scan) begin
        dg = (m_k / DigPer) % Digits;
        ph = (m_k / SubDiv) % 16;
        lit = (ph != 0) && (ph <= int'(nx_br));
        blank = nx_lz && (dg != 0) && ((m_act >> (4 * dg)) == 16'h0);
        e.sel = 4'b0001 << dg;
        e.fd = fr;
        if (lit) begin
          e.seg = blank ? 7'h00 : hex_tbl[m_act[4*dg +: 4]];
          e.dp = m_adp[dg];
        end
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 16'h0, 4'h0);
  endtask

  task automatic run_to(input int m);
    int guard = 0;
    do begin
      tick(1'b0, 16'h0, 4'h0);
      guard++;
    end while ((m_k % Frame) != m && guard < 2 * Frame);
    if (guard >= 2 * Frame) chk({tag, "_run_to_bound"}, 32'(guard), 32'(2 * Frame - 1));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic spot(input string name, input int m, input logic [6:0] seg, input logic [3:0] sel);
    run_to(m);
    settle();
    chk({name, "_seg"}, 32'(bus.segments), 32'(seg));
    chk({name, "_sel"}, 32'(bus.digit_sel), 32'(sel));
  endtask

  // Monitor: pops one expectation per clock edge and tallies activity counters.
  obs_t  mon_g, mon_e;
  string mon_t;
  always @(posedge clk) begin
    #1;
    mon_g = {bus.segments, bus.dp_out, bus.digit_sel, bus.frame_done};
    if (mon_g.fd) frame_cnt++;
    if (mon_g.seg != 7'h00) lit_cnt++;
    if (mon_g.sel != 4'h0) sel_cnt++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL %s @%0t: got seg=%h dp=%b sel=%b fd=%b, required seg=%h dp=%b sel=%b fd=%b",
                 mon_t, $time, mon_g.seg, mon_g.dp, mon_g.sel, mon_g.fd,
                 mon_e.seg, mon_e.dp, mon_e.sel, mon_e.fd);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; rst_next = 1'b0; nx_en = 1'b0; nx_lz = 1'b0; nx_br = 4'h0; tag = "reset";
    bus.enable = 1'b0; bus.value = '0; bus.dp = '0; bus.load = 1'b0;
    bus.lz_blank = 1'b0; bus.brightness = 4'h0;
    m_scan = 1'b0; m_k = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 32'({bus.segments, bus.dp_out, bus.digit_sel, bus.frame_done}), 32'h0);
    run(3);

    // Basic scan of 0x12AF at full brightness.
    rst_next = 1'b1; tag = "idle_load";
    tick(1'b1, 16'h12AF, 4'b0101);
    run(2);
    nx_en = 1'b1; nx_br = 4'd15; tag = "scan_12af";
    tick(1'b0, 16'h0, 4'h0);
    spot("d0_phase0", 2, 7'h00, 4'b0001);
    spot("d0", 5, 7'h71, 4'b0001);
    spot("d1", 69, 7'h77, 4'b0010);
    spot("d2", 133, 7'h5B, 4'b0100);
    spot("d3", 197, 7'h06, 4'b1000);
    frame_cnt = 0; lit_cnt = 0;
    run(Frame);
    settle();
    chk("frame_done_per_256", 32'(frame_cnt), 32'd1);
    chk("lit_cycles_br15", 32'(lit_cnt), 32'd240);

    // Leading-zero suppression on 0x0050.
    tag = "lz_blank"; nx_lz = 1'b1;
    tick(1'b1, 16'h0050, 4'h0);
    run_to(0);
    spot("lz_d0", 5, 7'h3F, 4'b0001);
    spot("lz_d1", 69, 7'h6D, 4'b0010);
    spot("lz_d2", 133, 7'h00, 4'b0100);
    spot("lz_d3", 197, 7'h00, 4'b1000);
    nx_lz = 1'b0; tag = "lz_off";
    spot("nolz_d2", 133, 7'h3F, 4'b0100);
    spot("nolz_d3", 197, 7'h3F, 4'b1000);

    // Brightness duty.
    tag = "bright4";
    tick(1'b1, 16'h8888, 4'h0);
    nx_br = 4'd4;
    run_to(0);
    settle();
    frame_cnt = 0; lit_cnt = 0;
    run(Frame);
    settle();
    chk("lit_cycles_br4", 32'(lit_cnt), 32'd64);
    chk("frame_done_br4", 32'(frame_cnt), 32'd1);
    tag = "bright0"; nx_br = 4'd0;
    tick(1'b0, 16'h0, 4'h0);
    settle();
    frame_cnt = 0; lit_cnt = 0; sel_cnt = 0;
    run(Frame);
    settle();
    chk("lit_cycles_br0", 32'(lit_cnt), 32'd0);
    chk("sel_active_br0", 32'(sel_cnt), 32'd256);
    chk("frame_done_br0", 32'(frame_cnt), 32'd1);

    // Pending buffer: last load before the wrap wins; load on the wrap edge goes straight in.
    tag = "pending"; nx_br = 4'd15;
    tick(1'b1, 16'h1111, 4'h0);
    run_to(0);
    spot("pend_base", 69, 7'h06, 4'b0010);
    run_to(100);
    tick(1'b1, 16'h1111, 4'h0);
    run_to(150);
    tick(1'b1, 16'h2222, 4'h0);
    spot("pend_hold", 197, 7'h06, 4'b1000);
    spot("pend_swap_d0", 5, 7'h5B, 4'b0001);
    spot("pend_swap_d1", 69, 7'h5B, 4'b0010);
    run_to(255);
    tag = "wrap_load";
    tick(1'b1, 16'h9999, 4'h0);
    spot("wrap_load_d0", 5, 7'h67, 4'b0001);

    // Asynchronous reset in the middle of digit 2.
    tag = "async_rst";
    run_to(138);
    settle();
    rst_n = 1'b0; rst_next = 1'b0;
    #1;
    chk("async_rst_outputs",
        32'({bus.segments, bus.dp_out, bus.digit_sel, bus.frame_done}), 32'h0);
    run(3);
    rst_next = 1'b1; tag = "post_rst";
    tick(1'b0, 16'h0, 4'h0);
    spot("post_rst_d0", 5, 7'h3F, 4'b0001);

    // Enable drop mid-frame, then restart.
    tag = "en_drop";
    tick(1'b1, 16'h12AF, 4'h0);
    run_to(0);
    run_to(100);
    settle();
    frame_cnt = 0;
    nx_en = 1'b0;
    tick(1'b0, 16'h0, 4'h0);
    settle();
    chk("en_drop_sel", 32'(bus.digit_sel), 32'h0);
    chk("en_drop_seg", 32'(bus.segments), 32'h0);
    run(300);
    settle();
    chk("en_drop_no_frame", 32'(frame_cnt), 32'd0);
    tag = "restart"; nx_en = 1'b1;
    tick(1'b0, 16'h0, 4'h0);
    settle();
    chk("restart_sel", 32'(bus.digit_sel), 32'h1);
    spot("restart_d0", 5, 7'h71, 4'b0001);

    tag = "end";
    run(2);
    settle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
